pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator for the simplified RISC-V core: holds the PC register and computes the next PC every cycle.
- Next-PC sources: sequential (+4), PC-relative branch/JAL, register-indirect JALR, and trap redirect.
- Adds stall, a boot cycle, and misaligned-target fault handling.
- Sits between decode/execute (redirect requests) and instruction fetch (consumes pc/pc_valid).

Parameters:
WIDTH, 32, address/data width in bits (>= 8)
RESET_PC, 32'h0000_0000, PC value loaded on reset (WIDTH bits, word aligned)
RAS_DEPTH, 4, return-address-stack entries (used only with PC_GEN_RAS_EN; power of 2, >= 2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC; redirect requests ignored while high
branch  in  1  taken branch/JAL: target = pc + imm
imm  in  WIDTH  sign-extended byte offset for branch
jalr  in  1  register-indirect jump: target = (rs1 + imm) & ~1
rs1  in  WIDTH  base register value for jalr
trap  in  1  trap redirect request
trap_vec  in  WIDTH  trap handler address (word aligned)
pc  out  WIDTH  current PC presented to fetch
pc_valid  out  1  pc is a valid fetch address
pc_plus4  out  WIDTH  pc + 4 (link value), combinational
misaligned  out  1  one-cycle pulse: computed target had bits [1:0] != 0

Behaviour:
- Reset (rst high at edge): pc = RESET_PC, state = BOOT, pc_valid = 0, misaligned = 0, RAS pointer/count = 0. Reset overrides all other inputs, including mid-stall and mid-fault.
- States:
  - BOOT: one cycle, pc_valid = 0, then RUN.
  - RUN: pc_valid = 1.
  - FAULT: pc_valid = 0, pc held.
- RUN next-PC priority: trap > jalr > branch > sequential.
  - trap: pc <= trap_vec, applied even when stall = 1.
  - stall = 1 (no trap): pc held, no other input sampled.
  - jalr: target = (rs1 + imm) with bit 0 cleared.
  - branch: target = pc + imm.
  - Otherwise: pc + 4.
- Arithmetic: all additions modulo 2^WIDTH; wrap-around is silent (pc = 2^WIDTH - 4 advances to 0).
- Misalignment: a jalr/branch target with target[1:0] != 0 causes:
  - pc unchanged;
  - misaligned = 1 for exactly one cycle;
  - state <= FAULT.
- FAULT: only trap (-> pc = trap_vec, RUN) or rst exits. branch, jalr and stall are ignored.
- Redirect latency: request sampled at edge N; new pc and pc_valid visible after edge N (one cycle).
- Simultaneous branch + jalr: jalr wins. Simultaneous trap + anything: trap wins, and misalignment is not checked.

Optional Feature:
PC_GEN_RAS_EN
- Defined: adds inputs is_call (1) and is_ret (1) and a RAS_DEPTH-entry circular return-address stack.
- Call (branch or jalr with is_call): push pc_plus4.
- jalr with is_ret and stack non-empty: target = popped entry instead of rs1 + imm; misalignment is still checked.
- is_call && is_ret on the same jalr: pop, then push.
- Push when full overwrites the oldest entry (count saturates). Pop when empty falls back to rs1 + imm.
- Stack is untouched while stall, trap or FAULT is active.
- Undefined: no ports, no stack; behaviour exactly as above.

Decomposition:
- Shared package core_pkg:
  - pc_state_e enum {BOOT, RUN, FAULT};
  - INSTR_BYTES = 4 constant;
  - RESET_PC default localparam.
- One natural sub-module: pc_ras (circular stack: push, pop, empty, full), instantiated only under PC_GEN_RAS_EN.

Test Plan:
- Reset then release, no requests: cycle 0 pc_valid = 0 (BOOT); then pc = 0x0, 0x4, 0x8 with pc_valid = 1.
- pc = 0x100, branch = 1, imm = 0xFFFF_FFF0 -> next pc = 0xF0. Same cycle also jalr = 1, rs1 = 0x2000, imm = 0x5 -> next pc = 0x2004 (jalr wins, bit 0 cleared).
- pc = 0x40, branch with imm = 0x6 -> misaligned pulses 1 cycle, pc stays 0x40, pc_valid = 0. branch/stall are then ignored; trap with trap_vec = 0x800 -> pc = 0x800, pc_valid = 1.
- stall = 1 for 3 cycles at pc = 0x20 with branch = 1 -> pc holds 0x20. trap during stall, trap_vec = 0x900 -> pc = 0x900 next cycle.
- pc = 0xFFFF_FFFC sequential -> pc = 0x0. rst asserted in FAULT -> pc = RESET_PC, BOOT.
- PC_GEN_RAS_EN:
  - Call at pc 0x10 then ret with rs1 = 0x0 -> pc = 0x14.
  - 5 calls with RAS_DEPTH = 4, then 5 rets -> first 4 rets return the newest 4 links; 5th uses rs1 + imm.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the PC generator slice.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect-request / fetch-address bundle between decode-execute and pc_gen.
// With PC_GEN_RAS_EN defined, the bundle also carries the call/return hints.
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch;
  logic [WIDTH-1:0] imm;
  logic             jalr;
  logic [WIDTH-1:0] rs1;
  logic             trap;
  logic [WIDTH-1:0] trap_vec;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_plus4;
  logic             misaligned;

`ifdef PC_GEN_RAS_EN
  logic is_call;
  logic is_ret;

  modport master (
    output stall, branch, imm, jalr, rs1, trap, trap_vec, is_call, is_ret,
    input  pc, pc_valid, pc_plus4, misaligned
  );
  modport slave (
    input  stall, branch, imm, jalr, rs1, trap, trap_vec, is_call, is_ret,
    output pc, pc_valid, pc_plus4, misaligned
  );
`else
  modport master (
    output stall, branch, imm, jalr, rs1, trap, trap_vec,
    input  pc, pc_valid, pc_plus4, misaligned
  );
  modport slave (
    input  stall, branch, imm, jalr, rs1, trap, trap_vec,
    output pc, pc_valid, pc_plus4, misaligned
  );
`endif

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        ptr_d = ptr_q + PTR_W'(1);
        if (!full) count_d = count_q + (PTR_W+1)'(1);
      end
      2'b01: begin
        ptr_d   = top_idx;
        count_d = count_q - (PTR_W+1)'(1);
      end
      // pop+push replaces the top entry in place
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[pop_i ? top_idx : ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/FAULT control with trap > jalr > branch > +4.
// Optional return-address stack is enabled by defining PC_GEN_RAS_EN.
module pc_gen
  import core_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
`ifdef PC_GEN_RAS_EN
  ,
  parameter int               RAS_DEPTH = 4
`endif
) (
  input logic    clk,
  input logic    rst,
  pc_gen_if.slave bus
);
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic [WIDTH-1:0] pc_plus4, branch_tgt, jalr_tgt, target;
  logic             redirect, target_bad, take;

  assign pc_plus4   = pc_q + WIDTH'(INSTR_BYTES);
  assign branch_tgt = pc_q + bus.imm;
  assign jalr_tgt   = (bus.rs1 + bus.imm) & ~WIDTH'(1);
  assign redirect   = bus.jalr | bus.branch;
  assign target_bad = (target[1:0] != 2'b00);
  assign take       = (state_q == RUN) & ~bus.trap & ~bus.stall & redirect & ~target_bad;

`ifdef PC_GEN_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_pop_ok;

  assign ras_pop_ok = bus.jalr & bus.is_ret & ~ras_empty;
  assign target     = bus.jalr ? (ras_pop_ok ? ras_top : jalr_tgt) : branch_tgt;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (take & bus.is_call),
    .pop_i       (take & ras_pop_ok),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  assign target = bus.jalr ? jalr_tgt : branch_tgt;
`endif

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap) begin
          pc_d = bus.trap_vec;
        end else if (!bus.stall) begin
          if (redirect && target_bad) begin
            misaligned_d = 1'b1;
            state_d      = FAULT;
          end else if (redirect) begin
            pc_d = target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      FAULT: begin
        if (bus.trap) begin
          pc_d    = bus.trap_vec;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = (state_q == RUN);
  assign bus.pc_plus4   = pc_plus4;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: reference model pushes expectations, monitor compares.
module tb_pc_gen;
  localparam int          WIDTH  = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          RAS_D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_if #(.WIDTH(WIDTH)) bus ();

`ifdef PC_GEN_RAS_EN
  logic is_call_v, is_ret_v;
  assign bus.is_call = is_call_v;
  assign bus.is_ret  = is_ret_v;

  pc_gen #(.WIDTH(WIDTH), .RESET_PC(RST_PC), .RAS_DEPTH(RAS_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  pc_gen #(.WIDTH(WIDTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: 0 = boot, 1 = running, 2 = faulted; RAS as a plain queue.
  int          m_state = 0;
  logic [31:0] m_pc    = RST_PC;
  logic        m_mis   = 1'b0;
  logic [31:0] ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
`ifdef PC_GEN_RAS_EN
    bit pop_ok;
`endif
    if (rst) begin
      m_pc    = RST_PC;
      m_state = 0;
      m_mis   = 1'b0;
      ras.delete();
    end else begin
      m_mis = 1'b0;
      case (m_state)
        0: m_state = 1;
        1: begin
          if (bus.trap) m_pc = bus.trap_vec;
          else if (!bus.stall) begin
            if (bus.jalr || bus.branch) begin
              if (bus.jalr) tgt = (bus.rs1 + bus.imm) & 32'hFFFF_FFFE;
              else          tgt = m_pc + bus.imm;
`ifdef PC_GEN_RAS_EN
              pop_ok = bus.jalr && is_ret_v && (ras.size() > 0);
              if (pop_ok) tgt = ras[$];
`endif
              if (tgt[1:0] != 2'b00) begin
                m_mis   = 1'b1;
                m_state = 2;
              end else begin
`ifdef PC_GEN_RAS_EN
                if (pop_ok) void'(ras.pop_back());
                if (is_call_v) begin
                  ras.push_back(m_pc + 32'd4);
                  if (ras.size() > RAS_D) void'(ras.pop_front());
                end
`endif
                m_pc = tgt;
              end
            end else begin
              m_pc = m_pc + 32'd4;
            end
          end
        end
        default: begin
          if (bus.trap) begin
            m_pc    = bus.trap_vec;
            m_state = 1;
          end
        end
      endcase
    end
    exp_q.push_back('{pc: m_pc, valid: (m_state == 1), mis: m_mis});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit st, input bit br, input bit jr, input bit tr,
                       input logic [31:0] im, input logic [31:0] r1, input logic [31:0] tv);
    bus.stall    = st;
    bus.branch   = br;
    bus.jalr     = jr;
    bus.trap     = tr;
    bus.imm      = im;
    bus.rs1      = r1;
    bus.trap_vec = tv;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: the DUT presents pc every cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", bus.pc, e.pc);
        check("pc_valid", {31'b0, bus.pc_valid}, {31'b0, e.valid});
        check("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
        check("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
`ifdef PC_GEN_RAS_EN
    is_call_v = 1'b0;
    is_ret_v  = 1'b0;
`endif
    idle(2);
    rst = 1'b0;
    idle(4);                                              // BOOT, then 0x0, 0x4, 0x8

    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h100);             // pc = 0x100
    drive(0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h0);       // -> 0xF0
    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h100);
    drive(0, 1, 1, 0, 32'h5, 32'h2000, 32'h0);            // jalr wins -> 0x2004

    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h40);
    drive(0, 1, 0, 0, 32'h6, 32'h0, 32'h0);               // misaligned -> FAULT
    drive(0, 1, 0, 0, 32'h10, 32'h0, 32'h0);              // ignored in FAULT
    drive(1, 0, 1, 0, 32'h10, 32'h100, 32'h0);            // ignored in FAULT
    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h800);             // -> 0x800, RUN

    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h20);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 32'h40, 32'h0, 32'h0);
    drive(1, 0, 0, 1, 32'h0, 32'h0, 32'h900);             // trap beats stall

    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFFC);
    idle(2);                                              // wraps to 0x0
    drive(0, 0, 1, 0, 32'h2, 32'h0, 32'h0);               // jalr target 0x2 -> FAULT
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

`ifdef PC_GEN_RAS_EN
    drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h10);
    is_call_v = 1'b1;
    drive(0, 1, 0, 0, 32'h100, 32'h0, 32'h0);             // call at 0x10, link 0x14
    is_call_v = 1'b0;
    is_ret_v  = 1'b1;
    drive(0, 0, 1, 0, 32'h0, 32'h0, 32'h0);               // ret -> 0x14
    is_ret_v  = 1'b0;
    is_call_v = 1'b1;
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
    is_call_v = 1'b0;
    is_ret_v  = 1'b1;
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 32'h0, 32'h300, 32'h0);
    is_ret_v  = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] im;
      im = 32'($signed($urandom_range(0, 255)) - 128) << 2;
      if ($urandom_range(0, 9) == 0) im = im + 32'($urandom_range(1, 3));
      rst = ($urandom_range(0, 99) == 0);
`ifdef PC_GEN_RAS_EN
      is_call_v = ($urandom_range(0, 3) == 0);
      is_ret_v  = ($urandom_range(0, 3) == 0);
`endif
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
            im, $urandom & 32'hFFFF_FFFD, $urandom & 32'hFFFF_FFFC);
    end
    rst = 1'b0;
    idle(2);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
